// File: rtl/bus_defs.sv
// rtl/bus_defs.sv - shared state encoding and constants for the CPU bus responder
package bus_defs;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WPOST = 2'd1,
        ST_RWAIT = 2'd2,
        ST_BLOCK = 2'd3
    } state_e;

    localparam int TMR_W = 16;
    localparam logic [7:0] ERR_RDATA = 8'hFF;
endpackage

// File: rtl/bus_timer.sv
// rtl/bus_timer.sv - loadable down-counter that flags the last counted cycle
import bus_defs::*;

module bus_timer (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             expire_o
);
    logic [TMR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the edge that would take the count from one to zero.
    assign expire_o = en_i & (cnt_q == TMR_W'(1));
endmodule

// File: rtl/bus_resp.sv
// rtl/bus_resp.sv - 65C02 bus responder steering accesses to fast and slow ports
import bus_defs::*;

module bus_resp #(
    parameter logic [15:0] FAST_MASK = 16'hFFFF,
    parameter int          TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [15:0] AB,
    input  logic [7:0]  DO,
    input  logic        WE,
    output logic [7:0]  DI,
    output logic        RDY,
    output logic        fast_en,
    output logic        fast_we,
    input  logic [7:0]  fast_dout,
    output logic        slow_req,
    output logic        slow_we,
    output logic [15:0] slow_addr,
    output logic [7:0]  slow_wdata,
    input  logic [7:0]  slow_rdata,
    input  logic        slow_ack,
    output logic        bus_err
);
    localparam logic [TMR_W-1:0] TO_VAL = TMR_W'(TIMEOUT);

    state_e      state_q, state_d;
    logic        req_q, req_d, pend_q, pend_d;
    logic        we_q, we_d, qwe_q, qwe_d;
    logic [15:0] addr_q, addr_d, qaddr_q, qaddr_d;
    logic [7:0]  wdata_q, wdata_d, qwdata_q, qwdata_d;
    logic [7:0]  hold_q, hold_d;
    logic        sel_slow_q, sel_slow_d, err_q, err_d;
    logic        fast_page, acc_slow, ack_ok, expire, done, tmr_load;

    assign RDY       = (state_q == ST_IDLE) || (state_q == ST_WPOST);
    assign fast_page = FAST_MASK[AB[15:12]];
    assign acc_slow  = RDY & ~fast_page;
    assign ack_ok    = req_q & slow_ack;
    assign done      = ack_ok | expire;

    bus_timer u_timer (
        .clk        (clk),
        .rst_i      (RST),
        .load_i     (tmr_load),
        .load_val_i (TO_VAL),
        .en_i       (req_q & ~slow_ack),
        .expire_o   (expire)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        pend_d     = pend_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        qwe_d      = qwe_q;
        qaddr_d    = qaddr_q;
        qwdata_d   = qwdata_q;
        hold_d     = hold_q;
        sel_slow_d = sel_slow_q;
        err_d      = expire;
        tmr_load   = 1'b0;

        if (RDY) begin
            sel_slow_d = ~fast_page;
        end
        // A request issued right after a completion waits one idle cycle on req.
        if (pend_q) begin
            req_d    = 1'b1;
            pend_d   = 1'b0;
            tmr_load = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (acc_slow) begin
                    addr_d   = AB;
                    we_d     = WE;
                    wdata_d  = DO;
                    req_d    = 1'b1;
                    tmr_load = 1'b1;
                    state_d  = WE ? ST_WPOST : ST_RWAIT;
                end
            end
            ST_WPOST: begin
                if (done) begin
                    req_d = 1'b0;
                    if (acc_slow) begin
                        addr_d  = AB;
                        we_d    = WE;
                        wdata_d = DO;
                        pend_d  = 1'b1;
                        state_d = WE ? ST_WPOST : ST_RWAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (acc_slow) begin
                    qaddr_d  = AB;
                    qwe_d    = WE;
                    qwdata_d = DO;
                    state_d  = ST_BLOCK;
                end
            end
            ST_BLOCK: begin
                if (done) begin
                    req_d   = 1'b0;
                    addr_d  = qaddr_q;
                    we_d    = qwe_q;
                    wdata_d = qwdata_q;
                    pend_d  = 1'b1;
                    state_d = qwe_q ? ST_WPOST : ST_RWAIT;
                end
            end
            ST_RWAIT: begin
                if (done) begin
                    req_d   = 1'b0;
                    hold_d  = ack_ok ? slow_rdata : ERR_RDATA;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            pend_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            qwe_q      <= 1'b0;
            qaddr_q    <= '0;
            qwdata_q   <= '0;
            hold_q     <= '0;
            sel_slow_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            pend_q     <= pend_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            qwe_q      <= qwe_d;
            qaddr_q    <= qaddr_d;
            qwdata_q   <= qwdata_d;
            hold_q     <= hold_d;
            sel_slow_q <= sel_slow_d;
            err_q      <= err_d;
        end
    end

    assign fast_en    = RDY & fast_page;
    assign fast_we    = fast_en & WE;
    assign slow_req   = req_q;
    assign slow_we    = we_q;
    assign slow_addr  = addr_q;
    assign slow_wdata = wdata_q;
    assign bus_err    = err_q;
    assign DI         = sel_slow_q ? hold_q : fast_dout;
endmodule

// File: tb/tb_bus_resp.sv
// tb/tb_bus_resp.sv - directed scoreboard bench for bus_resp
module tb_bus_resp;
    logic        clk = 1'b0;
    logic        RST;
    logic [15:0] AB;
    logic [7:0]  DO;
    logic        WE;
    logic [7:0]  DI;
    logic        RDY;
    logic        fast_en, fast_we;
    logic [7:0]  fast_dout;
    logic        slow_req, slow_we;
    logic [15:0] slow_addr;
    logic [7:0]  slow_wdata, slow_rdata;
    logic        slow_ack, bus_err;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    bus_resp #(.FAST_MASK(16'h0001), .TIMEOUT(4)) dut (
        .clk(clk), .RST(RST), .AB(AB), .DO(DO), .WE(WE), .DI(DI), .RDY(RDY),
        .fast_en(fast_en), .fast_we(fast_we), .fast_dout(fast_dout),
        .slow_req(slow_req), .slow_we(slow_we), .slow_addr(slow_addr),
        .slow_wdata(slow_wdata), .slow_rdata(slow_rdata), .slow_ack(slow_ack),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_di(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, DI, e);
        end
    endtask

    task automatic fast_read(input string tag, input logic [15:0] a, input logic [7:0] v);
        AB = a;
        WE = 1'b0;
        #1;
        chk({tag, "_fast_en"}, fast_en, 1'b1);
        exp_q.push_back(v);
        tick;
        fast_dout = v;
        #1;
        chk({tag, "_rdy"}, RDY, 1'b1);
        pop_di({tag, "_di"});
    endtask

    initial begin
        int low, reqc, n, cyc, errc;
        RST = 1'b1; AB = 16'h0000; DO = 8'h00; WE = 1'b0;
        fast_dout = 8'hA7; slow_rdata = 8'h00; slow_ack = 1'b0;
        tick;
        chk("rst_rdy", RDY, 1'b1);
        chk("rst_req", slow_req, 1'b0);
        chk("rst_we", slow_we, 1'b0);
        chk("rst_addr", slow_addr, 16'h0000);
        chk("rst_wdata", slow_wdata, 8'h00);
        chk("rst_err", bus_err, 1'b0);
        chk("rst_di_fast", DI, 8'hA7);
        RST = 1'b0;
        tick;

        // fast read of page 0
        fast_read("f0010", 16'h0010, 8'h3C);
        chk("f0010_req", slow_req, 1'b0);

        // slow read, ack during the fourth request cycle
        AB = 16'hD000; WE = 1'b0;
        #1;
        chk("sr_fast_en", fast_en, 1'b0);
        exp_q.push_back(8'h5A);
        tick;
        chk("sr_req", slow_req, 1'b1);
        chk("sr_addr", slow_addr, 16'hD000);
        chk("sr_we", slow_we, 1'b0);
        low = 0; reqc = 0; n = 0;
        while (RDY === 1'b0 && n < 40) begin
            n++; low++;
            if (slow_req === 1'b1) reqc++;
            if (reqc == 4) begin
                slow_ack = 1'b1; slow_rdata = 8'h5A;
            end
            tick;
            slow_ack = 1'b0; slow_rdata = 8'h00;
        end
        chk("sr_stall", low, 4);
        chk("sr_rdy", RDY, 1'b1);
        pop_di("sr_di");
        chk("sr_req_drop", slow_req, 1'b0);
        fast_read("sr_f1", 16'h0020, 8'h11);
        fast_read("sr_f2", 16'h0021, 8'h22);
        chk("sr_hold", dut.hold_q, 8'h5A);

        // posted slow write with two fast reads before ack
        AB = 16'hD001; WE = 1'b1; DO = 8'h33;
        tick;
        chk("pw_rdy", RDY, 1'b1);
        chk("pw_req", slow_req, 1'b1);
        chk("pw_we", slow_we, 1'b1);
        chk("pw_addr", slow_addr, 16'hD001);
        chk("pw_wdata0", slow_wdata, 8'h33);
        DO = 8'h00;
        fast_read("pw_f1", 16'h0030, 8'h44);
        chk("pw_wdata1", slow_wdata, 8'h33);
        fast_read("pw_f2", 16'h0031, 8'h55);
        chk("pw_wdata2", slow_wdata, 8'h33);
        chk("pw_req2", slow_req, 1'b1);
        slow_ack = 1'b1; AB = 16'h0000;
        tick;
        slow_ack = 1'b0;
        chk("pw_req_drop", slow_req, 1'b0);
        chk("pw_rdy_end", RDY, 1'b1);
        chk("pw_err", bus_err, 1'b0);

        // slow write immediately followed by slow read: BLOCK
        AB = 16'hD003; WE = 1'b1; DO = 8'h66;
        tick;
        AB = 16'hD002; WE = 1'b0;
        exp_q.push_back(8'h77);
        tick;
        chk("blk_rdy", RDY, 1'b0);
        chk("blk_addr", slow_addr, 16'hD003);
        chk("blk_we", slow_we, 1'b1);
        tick;
        chk("blk_rdy2", RDY, 1'b0);
        chk("blk_req2", slow_req, 1'b1);
        slow_ack = 1'b1;
        tick;
        slow_ack = 1'b0;
        chk("blk_gap", slow_req, 1'b0);
        chk("blk_rdy3", RDY, 1'b0);
        tick;
        chk("blk_rd_req", slow_req, 1'b1);
        chk("blk_rd_addr", slow_addr, 16'hD002);
        chk("blk_rd_we", slow_we, 1'b0);
        slow_ack = 1'b1; slow_rdata = 8'h77;
        tick;
        slow_ack = 1'b0; slow_rdata = 8'h00;
        chk("blk_rd_rdy", RDY, 1'b1);
        pop_di("blk_rd_di");

        // write acked in the same cycle a new slow write arrives
        AB = 16'hD006; WE = 1'b1; DO = 8'h55;
        tick;
        AB = 16'hD007; DO = 8'h66; slow_ack = 1'b1;
        tick;
        slow_ack = 1'b0; AB = 16'h0000; WE = 1'b0;
        chk("b2b_gap", slow_req, 1'b0);
        chk("b2b_rdy", RDY, 1'b1);
        tick;
        chk("b2b_req", slow_req, 1'b1);
        chk("b2b_addr", slow_addr, 16'hD007);
        chk("b2b_wdata", slow_wdata, 8'h66);
        slow_ack = 1'b1;
        tick;
        slow_ack = 1'b0;
        chk("b2b_done", slow_req, 1'b0);

        // timeout on a read with no ack
        AB = 16'hD004; WE = 1'b0;
        exp_q.push_back(8'hFF);
        tick;
        chk("to_req", slow_req, 1'b1);
        cyc = 1; errc = 0;
        while (slow_req === 1'b1 && cyc < 20) begin
            tick;
            if (bus_err === 1'b1) errc++;
            if (slow_req === 1'b1) cyc++;
        end
        chk("to_cycles", cyc, 4);
        chk("to_rdy", RDY, 1'b1);
        pop_di("to_di");
        AB = 16'h0000;
        tick;
        if (bus_err === 1'b1) errc++;
        chk("to_err_pulses", errc, 1);

        // reset while waiting on a slow read; late ack is ignored
        AB = 16'hD005; WE = 1'b0;
        tick;
        chk("rr_rdy0", RDY, 1'b0);
        chk("rr_req0", slow_req, 1'b1);
        RST = 1'b1;
        tick;
        RST = 1'b0;
        chk("rr_req", slow_req, 1'b0);
        chk("rr_rdy", RDY, 1'b1);
        chk("rr_state", dut.state_q, 2'd0);
        AB = 16'h0000; slow_ack = 1'b1; slow_rdata = 8'h99;
        tick;
        slow_ack = 1'b0;
        chk("rr_req_late", slow_req, 1'b0);
        chk("rr_err", bus_err, 1'b0);
        chk("rr_hold", dut.hold_q, 8'h00);
        fast_read("rr_f", 16'h0040, 8'hC3);

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
